sdio_cmd_rx: RTL and testbench
==============================

Name: sdio_cmd_rx

Overview:
Card-side SDIO command receiver. It sits directly downstream of the CMD pad (pullup-terminated, driven by the host model) and deserialises 48-bit host-to-card command frames sampled on the SDIO clock. It checks CRC7 and the framing bits, then presents index and argument to the card command decoder over a valid/ready handshake. Serial reception runs independently of the output holding register, so back-to-back frames are tolerated.

Parameters:
CRC_EN, 1, 1 = compare received CRC7 against computed; 0 = cmd_crc_err forced 0
DIR_CHECK_EN, 1, 1 = flag transmission bit = 0 in cmd_dir_err; 0 = cmd_dir_err forced 0

Ports:
sdio_clk  in  1  SDIO clock; all logic on its rising edge
sdio_rst_n  in  1  reset, synchronous, active-low
rx_en  in  1  receive enable; 0 while the card drives CMD (response phase)
sd_cmd_in  in  1  CMD pad input, sampled on rising sdio_clk
cmd_valid  out  1  holding register contains a frame
cmd_ready  in  1  consumer accepts the frame when cmd_valid && cmd_ready
cmd_index  out  6  command index (frame bits 45:40)
cmd_arg  out  32  argument (frame bits 39:8)
cmd_crc_err  out  1  received CRC7 != computed CRC7
cmd_end_err  out  1  end bit sampled as 0
cmd_dir_err  out  1  transmission bit sampled as 0
rx_busy  out  1  frame reception in progress
rx_overrun  out  1  one-cycle pulse: completed frame dropped because holding register was full

Behaviour:
- Reset (sdio_rst_n = 0 at a rising edge): state IDLE, bit counter 0, CRC register 0. All outputs 0: cmd_valid, cmd_index, cmd_arg, all error flags, rx_busy, rx_overrun. Reset mid-frame discards the partial frame and any held frame.
- Frame format, MSB first: start(0), transmission(1), index[5:0], arg[31:0], crc7[6:0], end(1). 48 bits total.
- CRC7: polynomial x^7+x^3+1, initial value 0. Computed serially over the first 40 bits (start through arg[0]).
- State IDLE: when rx_en = 1 and sd_cmd_in = 0, the start bit is taken as bit 0. Go to RECV, count = 1, CRC updated with the 0. rx_busy = 1 from the next cycle.
- State RECV: one bit is shifted per cycle. Bits 1..39 update the CRC. Bits 40..46 are captured as the received CRC. Bit 47 is the end bit.
- On sampling bit 47: return to IDLE the same edge. A new start bit is accepted on the very next rising edge, so there is zero gap between frames. rx_busy drops the cycle after the end bit.
- Completion latency: cmd_valid and the payload/flags register on the edge that samples the end bit. They are visible the cycle after that edge.
- Errors never suppress the frame. The frame is presented with flags set. Flags are held with the frame and are valid only while cmd_valid = 1.
- Handshake:
  - cmd_valid stays high, with payload stable, until cmd_valid && cmd_ready at a rising edge.
  - cmd_ready is ignored while cmd_valid = 0.
  - There is no combinational path from cmd_ready to cmd_valid.
- Overflow: if a frame completes while cmd_valid = 1 and cmd_ready = 0, the new frame is dropped and the old frame is kept. rx_overrun pulses for exactly 1 cycle.
- Simultaneous completion and accept (cmd_valid && cmd_ready on the end-bit edge): the new frame is loaded, cmd_valid stays 1, no overrun.
- rx_en = 0 in RECV: abort to IDLE on that edge. No valid, no overrun; the partial frame is discarded.
- In IDLE with rx_en = 0, CMD is ignored even when low.
- A CMD value of 1 while in IDLE is idle bus (pullup) and produces no activity.

Test Plan:
- CMD0 frame 0x40_0000_0000_95 sent with cmd_ready = 1 -> cmd_valid for 1 cycle, index 0x00, arg 0x00000000, all error flags 0.
- CMD8 frame 0x48_0000_01AA_87, then immediately CMD17 frame 0x51_0000_0000_55 with zero gap; cmd_ready = 1 -> two valid pulses:
  - first: index 8, arg 0x000001AA
  - second: index 17, arg 0x00000000
- CMD8 frame with CRC field 0x44 (byte 0x89) -> index 8, arg 0x1AA, cmd_crc_err = 1. A second run with CRC_EN = 0 -> cmd_crc_err = 0.
- Hold cmd_ready = 0 and send CMD0 then CMD8 -> CMD0 held, rx_overrun pulses once at CMD8 completion. Raise cmd_ready -> CMD0 consumed, cmd_valid drops, no CMD8 presented.
- Send CMD8 with end bit 0 and transmission bit 0 -> cmd_end_err = 1 and cmd_dir_err = 1, payload still presented.
- Drop rx_en at bit 20 of a frame, then assert sdio_rst_n = 0 during another frame at bit 30 -> no cmd_valid, all outputs 0 after reset. A following CMD0 is received correctly.

Source files
------------

// File: rtl/sdio_cmd_rx.sv
// Card-side SDIO CMD line receiver: deserialises 48-bit host command frames,
// checks CRC7 and framing bits, and holds the result for a valid/ready consumer.
module sdio_cmd_rx #(
    parameter bit CRC_EN       = 1'b1,
    parameter bit DIR_CHECK_EN = 1'b1
) (
    input  logic        sdio_clk,
    input  logic        sdio_rst_n,
    input  logic        rx_en,
    input  logic        sd_cmd_in,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_err,
    output logic        cmd_end_err,
    output logic        cmd_dir_err,
    output logic        rx_busy,
    output logic        rx_overrun,
    output logic        dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Handshake: a frame transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_valid is a register and never depends combinationally on cmd_ready.

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [6:0]  crc_q, crc_d;
    logic [46:0] shift_q, shift_d;
    logic        frame_done;

    logic        valid_q, valid_d;
    logic [5:0]  index_q, index_d;
    logic [31:0] arg_q, arg_d;
    logic        crc_err_q, crc_err_d;
    logic        end_err_q, end_err_d;
    logic        dir_err_q, dir_err_d;
    logic        overrun_q, overrun_d;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_en && !sd_cmd_in) begin
                    state_d = RECV;
                    cnt_d   = 6'd1;
                    crc_d   = crc7_step(7'd0, 1'b0);
                    shift_d = 47'd0;
                end
            end
            RECV: begin
                if (!rx_en) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                    crc_d   = 7'd0;
                end else if (cnt_q == 6'd47) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    cnt_d      = 6'd0;
                    crc_d      = 7'd0;
                end else begin
                    shift_d = {shift_q[45:0], sd_cmd_in};
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q < 6'd40) begin
                        crc_d = crc7_step(crc_q, sd_cmd_in);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // At the end-bit edge shift_q[46] is the start bit and shift_q[0] is crc7[0].
    always_comb begin
        valid_d   = valid_q;
        index_d   = index_q;
        arg_d     = arg_q;
        crc_err_d = crc_err_q;
        end_err_d = end_err_q;
        dir_err_d = dir_err_q;
        overrun_d = 1'b0;
        if (frame_done) begin
            if (!valid_q || cmd_ready) begin
                valid_d   = 1'b1;
                index_d   = shift_q[44:39];
                arg_d     = shift_q[38:7];
                crc_err_d = CRC_EN && (crc_q != shift_q[6:0]);
                end_err_d = !sd_cmd_in;
                dir_err_d = DIR_CHECK_EN && !shift_q[45];
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && cmd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sdio_clk) begin
        if (!sdio_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            crc_q     <= 7'd0;
            shift_q   <= 47'd0;
            valid_q   <= 1'b0;
            index_q   <= 6'd0;
            arg_q     <= 32'd0;
            crc_err_q <= 1'b0;
            end_err_q <= 1'b0;
            dir_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            arg_q     <= arg_d;
            crc_err_q <= crc_err_d;
            end_err_q <= end_err_d;
            dir_err_q <= dir_err_d;
            overrun_q <= overrun_d;
        end
    end

    assign cmd_valid   = valid_q;
    assign cmd_index   = index_q;
    assign cmd_arg     = arg_q;
    assign cmd_crc_err = crc_err_q;
    assign cmd_end_err = end_err_q;
    assign cmd_dir_err = dir_err_q;
    assign rx_busy     = (state_q == RECV);
    assign rx_overrun  = overrun_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sdio_cmd_rx.sv
// Directed bench for sdio_cmd_rx: two instances (checks enabled / disabled) share
// one CMD line; expected frames are queued by the driver and popped on handshake.
module tb_sdio_cmd_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en = 1'b0;
    logic cmd_in = 1'b1;
    logic ready = 1'b0;

    logic        a_valid, a_crc, a_end, a_dir, a_busy, a_ovr, a_state;
    logic [5:0]  a_index;
    logic [31:0] a_arg;
    logic        b_valid, b_crc, b_end, b_dir, b_busy, b_ovr, b_state;
    logic [5:0]  b_index;
    logic [31:0] b_arg;

    int checks = 0;
    int failures = 0;
    int valid_cyc = 0;
    int busy_cyc = 0;
    int ovr_a = 0;
    int ovr_b = 0;

    // packed expectation: {index[5:0], arg[31:0], crc_err, end_err, dir_err}
    logic [40:0] exp_q[$];
    logic [40:0] exp2_q[$];
    logic [40:0] e_a, e_b;

    always #5 clk = ~clk;

    sdio_cmd_rx #(.CRC_EN(1'b1), .DIR_CHECK_EN(1'b1)) dut_a (
        .sdio_clk(clk), .sdio_rst_n(rst_n), .rx_en(rx_en), .sd_cmd_in(cmd_in),
        .cmd_valid(a_valid), .cmd_ready(ready), .cmd_index(a_index), .cmd_arg(a_arg),
        .cmd_crc_err(a_crc), .cmd_end_err(a_end), .cmd_dir_err(a_dir),
        .rx_busy(a_busy), .rx_overrun(a_ovr), .dbg_state(a_state)
    );

    sdio_cmd_rx #(.CRC_EN(1'b0), .DIR_CHECK_EN(1'b0)) dut_b (
        .sdio_clk(clk), .sdio_rst_n(rst_n), .rx_en(rx_en), .sd_cmd_in(cmd_in),
        .cmd_valid(b_valid), .cmd_ready(ready), .cmd_index(b_index), .cmd_arg(b_arg),
        .cmd_crc_err(b_crc), .cmd_end_err(b_end), .cmd_dir_err(b_dir),
        .rx_busy(b_busy), .rx_overrun(b_ovr), .dbg_state(b_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are registered, inputs change just after posedge, so the
    // negedge sees the exact values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid) valid_cyc++;
            if (a_busy) busy_cyc++;
            if (a_ovr) ovr_a++;
            if (b_ovr) ovr_b++;
            if (a_valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("a_unexpected_frame", {a_index, a_arg}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e_a = exp_q.pop_front();
                    chk("a_index", a_index, e_a[40:35]);
                    chk("a_arg", a_arg, e_a[34:3]);
                    chk("a_flags", {a_crc, a_end, a_dir}, e_a[2:0]);
                end
            end
            if (b_valid && ready) begin
                if (exp2_q.size() == 0) begin
                    chk("b_unexpected_frame", {b_index, b_arg}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e_b = exp2_q.pop_front();
                    chk("b_index", b_index, e_b[40:35]);
                    chk("b_arg", b_arg, e_b[34:3]);
                    chk("b_flags", {b_crc, b_end, b_dir}, e_b[2:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc();
            cmd_in = 1'b1;
        end
    endtask

    // Flags given are for dut_a; dut_b has CRC and direction checks disabled.
    task automatic send_frame(input logic [47:0] f, input logic ce, input logic ee,
                              input logic de, input bit push, input int abort_at,
                              input int rst_at, input int ready_at);
        if (push) begin
            exp_q.push_back({f[45:40], f[39:8], ce, ee, de});
            exp2_q.push_back({f[45:40], f[39:8], 1'b0, ee, 1'b0});
        end
        for (int i = 0; i < 48; i++) begin
            cyc();
            if (i == abort_at) begin
                rx_en = 1'b0;
                cmd_in = 1'b1;
                cyc();
                rx_en = 1'b1;
                return;
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                cmd_in = 1'b1;
                exp_q.delete();
                exp2_q.delete();
                return;
            end
            if (i == ready_at) ready = 1'b1;
            cmd_in = f[47-i];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_index"}, a_index, 0);
        chk({tag, "_arg"}, a_arg, 0);
        chk({tag, "_flags"}, {a_crc, a_end, a_dir}, 0);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_overrun"}, a_ovr, 0);
        chk({tag, "_b_valid"}, b_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        chk_all_zero("reset");
        cyc();
        rst_n = 1'b1;
        rx_en = 1'b1;
        ready = 1'b1;
        idle(3);

        // CMD0, single valid pulse, busy for 47 cycles
        valid_cyc = 0;
        busy_cyc = 0;
        send_frame(48'h40_0000_0000_95, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(4);
        chk("cmd0_valid_cycles", valid_cyc, 1);
        chk("cmd0_busy_cycles", busy_cyc, 47);
        chk("cmd0_busy_after", a_busy, 0);

        // CMD8 then CMD17 with zero gap
        valid_cyc = 0;
        send_frame(48'h48_0000_01AA_87, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        send_frame(48'h51_0000_0000_55, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(4);
        chk("b2b_valid_cycles", valid_cyc, 2);

        // CMD8 with corrupted CRC field
        send_frame(48'h48_0000_01AA_89, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(4);

        // Overflow: CMD0 held, CMD8 dropped
        ready = 1'b0;
        ovr_a = 0;
        ovr_b = 0;
        send_frame(48'h40_0000_0000_95, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        send_frame(48'h48_0000_01AA_87, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        idle(3);
        chk("ovr_a_pulses", ovr_a, 1);
        chk("ovr_b_pulses", ovr_b, 1);
        @(negedge clk);
        chk("ovr_held_valid", a_valid, 1);
        chk("ovr_held_index", a_index, 6'h00);
        chk("ovr_held_arg", a_arg, 32'h0);
        cyc();
        ready = 1'b1;
        idle(3);
        chk("ovr_drained_valid", a_valid, 0);

        // Accept on the same edge that completes the next frame
        ready = 1'b0;
        ovr_a = 0;
        send_frame(48'h40_0000_0000_95, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        send_frame(48'h48_0000_01AA_87, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 47);
        idle(3);
        chk("simul_no_overrun", ovr_a, 0);
        chk("simul_drained_valid", a_valid, 0);

        // End bit 0 and transmission bit 0 (CRC mismatches as a consequence)
        send_frame(48'h08_0000_01AA_86, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, -1);
        idle(4);

        // CMD low while rx_en = 0 in IDLE is ignored
        valid_cyc = 0;
        busy_cyc = 0;
        rx_en = 1'b0;
        repeat (6) begin
            cyc();
            cmd_in = 1'b0;
        end
        cyc();
        cmd_in = 1'b1;
        rx_en = 1'b1;
        idle(2);
        chk("rxen_off_busy", busy_cyc, 0);
        chk("rxen_off_valid", valid_cyc, 0);

        // Abort at bit 20
        valid_cyc = 0;
        busy_cyc = 0;
        send_frame(48'h48_0000_01AA_87, 1'b0, 1'b0, 1'b0, 1'b0, 20, -1, -1);
        idle(4);
        chk("abort_valid", valid_cyc, 0);
        chk("abort_busy_cycles", busy_cyc, 20);

        // Reset at bit 30 while a frame is held
        ready = 1'b0;
        send_frame(48'h40_0000_0000_95, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(2);
        @(negedge clk);
        chk("pre_reset_held", a_valid, 1);
        send_frame(48'h48_0000_01AA_87, 1'b0, 1'b0, 1'b0, 1'b0, -1, 30, -1);
        repeat (2) @(posedge clk);
        chk_all_zero("midreset");
        cyc();
        rst_n = 1'b1;
        ready = 1'b1;
        idle(3);

        valid_cyc = 0;
        send_frame(48'h40_0000_0000_95, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, -1);
        idle(4);
        chk("post_reset_valid_cycles", valid_cyc, 1);

        chk("a_exp_queue_empty", exp_q.size(), 0);
        chk("b_exp_queue_empty", exp2_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
